uart_rx_fifo_ctrl: RTL and testbench
====================================

Name: uart_rx_fifo_ctrl

Overview:
- Sequences the UART receive path.
- Accepts completed frames from the receiver, checks parity against the programmed mode, and tags each word with parity and framing errors.
- Buffers tagged words in an internal FIFO and serves them to the bus-side register interface.
- Generates overrun, receive-timeout and level interrupts, and returns the clear pulse for the receiver's framing-error flag.

Parameters:
- DEPTH, 16, FIFO entries; power of two, 4..64.
- AW, 4, log2(DEPTH).
- TIMEOUT_TICKS, 32, baud ticks of inactivity before the timeout flag sets.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- rx_wr_req  in  1  frame-done level from the receiver; may be asynchronous to clk.
- rx_data  in  9  [7:0] data, [8] raw parity bit; [7] is meaningful only when word_size=1.
- rx_fe  in  1  receiver framing-error flag.
- rx_fe_clr  out  1  one-cycle pulse clearing the receiver FE flag.
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 mark.
- word_size  in  1  0 = 7-bit word, 1 = 8-bit word.
- brd_tick  in  1  one-clk pulse per bit period.
- rd_req  in  1  bus pop request, single-cycle.
- rd_valid  out  1  pulse, one cycle after an accepted pop.
- rd_data  out  10  {fe, pe, data[7:0]}; holds its value until the next pop.
- irq_level  in  AW+1  level threshold; 0 disables the level interrupt.
- clr_ov  in  1  clears the overrun flag.
- empty, full  out  1  FIFO status.
- count  out  AW+1  current occupancy.
- overrun  out  1  sticky; a word was dropped.
- timeout  out  1  sticky receive timeout.
- irq  out  1  (count>=irq_level && irq_level!=0) | overrun | timeout.

Behaviour:
- Reset (async):
  - FIFO pointers and count go to 0; empty=1, full=0.
  - overrun=0, timeout=0, irq=0, rd_valid=0, rd_data=0, rx_fe_clr=0.
  - Synchronizer, edge register and timeout counter are cleared; FSM enters S_IDLE.
  - Any capture in progress is discarded.
- rx_wr_req handling: passed through a 2-flop synchronizer, then rising-edge detected. A level held high yields one event only.
- Capture FSM states:
  - S_IDLE: on a detected edge -> S_CAPTURE.
  - S_CAPTURE: registers rx_data, rx_fe and the computed pe; asserts rx_fe_clr for this cycle; -> S_PUSH.
  - S_PUSH: writes {fe,pe,data} if not full, or if full with a simultaneous accepted pop; otherwise drops the word and sets overrun; -> S_IDLE.
  - Edges arriving in S_CAPTURE or S_PUSH are not lost: the edge flag stays pending until S_IDLE consumes it.
- Latency: the edge is detected in cycle N; the write happens at the end of N+2; empty deasserts and count increments visibly at cycle N+3.
- Parity:
  - d = word_size ? rx_data[7:0] : {1'b0, rx_data[6:0]}; p = rx_data[8].
  - none: pe=0.
  - even: pe = ^d ^ p.
  - odd: pe = ~(^d ^ p).
  - mark: pe = ~p.
- Stored data: in 7-bit mode, stored data[7] is forced to 0.
- Pop rules:
  - A pop with rd_req=1 and empty=0 advances the read pointer; rd_data and rd_valid update on the next edge.
  - rd_req while empty is ignored: no rd_valid, rd_data unchanged, pointers unchanged.
- Simultaneous push and pop: both execute; count is unchanged. When full, the pop frees the slot first, so no overrun occurs.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH; full = (count==DEPTH).
- overrun: set by a dropped word and held until clr_ov. If clr_ov coincides with a new drop, the set wins.
- Timeout counter:
  - Increments on brd_tick while empty=0.
  - Clears on any push, any pop, or empty=1.
  - On reaching TIMEOUT_TICKS it sets timeout and saturates.
  - timeout clears on an accepted pop or when empty becomes 1.
- irq is registered and follows its inputs with one cycle of delay.

Test Plan:
- Even parity, word_size=1: frame 0x0A5 with p=0 -> entry {0,0,0xA5}. Repeat with p=1 -> pe=1. In both cases rx_fe_clr pulses once and count=1 at N+3.
- 7-bit odd parity: rx_data=9'h1FF (d=0x7F, p=1) -> pe=1, stored data 0x7F. Then rx_data=9'h07F (p=0) -> pe=0. Mark mode with p=0 -> pe=1.
- Fill 16 words -> full=1. 17th frame -> dropped, overrun=1, irq=1, count=16. clr_ov -> overrun=0. 17th frame coinciding with a pop -> accepted, count stays 16, no overrun.
- Pop while empty -> no rd_valid, rd_data unchanged. Push 3 words then 3 pops -> FIFO-ordered data, empty=1 after the last pop.
- irq_level=4: after 3 words irq=0; after the 4th, irq=1 one cycle after count=4.
- One word held with 32 brd_ticks -> timeout=1. A pop clears it. Reset asserted mid-S_PUSH -> all outputs return to reset values and no write occurs.

Source files
------------

// File: rtl/uart_rx_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_ctrl
//
// Receive-side sequencer for a UART. A completed frame from the receiver is
// announced by the rx_wr_req level (possibly asynchronous to clk). That level
// is synchronised and edge detected, and then a small capture FSM does three
// things: it registers the frame, computes the parity error and pulses
// rx_fe_clr, and it pushes {fe, pe, data} into an internal FIFO that the bus
// side pops. The block also keeps a sticky overrun flag, a sticky receive
// timeout flag and a registered interrupt output.
//
// Ports:
//   clk, reset      system clock, asynchronous active-high reset
//   rx_wr_req       frame-done level from the receiver (async)
//   rx_data[8:0]    [7:0] data, [8] raw parity bit
//   rx_fe           receiver framing-error flag
//   rx_fe_clr       one-cycle pulse that clears the receiver FE flag
//   parity_mode     00 none, 01 even, 10 odd, 11 mark
//   word_size       0 = 7-bit word, 1 = 8-bit word
//   brd_tick        one-clk pulse per bit period
//   rd_req          bus pop request (single cycle)
//   rd_valid        pulse one cycle after an accepted pop
//   rd_data[9:0]    {fe, pe, data[7:0]}; holds until the next pop
//   irq_level       level interrupt threshold, 0 disables it
//   clr_ov          clears the overrun flag
//   empty, full     FIFO status
//   count           current occupancy, 0..DEPTH
//   overrun         sticky, a word was dropped
//   timeout         sticky receive timeout
//   irq             registered (level | overrun | timeout)
//   dbg_state       capture FSM state (0 idle, 1 capture, 2 push)
//
// Handshake: a pop is accepted on a rising clk edge where rd_req=1 and
// empty=0; rd_valid/rd_data reflect it from the following cycle. rd_req while
// empty has no effect.
// ---------------------------------------------------------------------------
module uart_rx_fifo_ctrl #(
    parameter int DEPTH         = 16,
    parameter int AW            = 4,
    parameter int TIMEOUT_TICKS = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rx_wr_req,
    input  logic [8:0]    rx_data,
    input  logic          rx_fe,
    output logic          rx_fe_clr,
    input  logic [1:0]    parity_mode,
    input  logic          word_size,
    input  logic          brd_tick,
    input  logic          rd_req,
    output logic          rd_valid,
    output logic [9:0]    rd_data,
    input  logic [AW:0]   irq_level,
    input  logic          clr_ov,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          overrun,
    output logic          timeout,
    output logic          irq,
    output logic [1:0]    dbg_state
);

    localparam int            TW       = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_TICKS);
    localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_PUSH    = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    logic          sync1_q, sync2_q, prev_q;
    logic          pend_q, pend_d;
    state_t        state_q, state_d;
    logic [7:0]    cap_data_q, cap_data_d;
    logic          cap_fe_q, cap_fe_d;
    logic          cap_pe_q, cap_pe_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [9:0]    rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic          ov_q, ov_d;
    logic          to_q, to_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          irq_q, irq_d;

    logic [9:0]    mem [DEPTH];

    // -----------------------------------------------------------------------
    // Combinational signals
    // -----------------------------------------------------------------------
    logic          rx_edge;
    logic          cap_en;
    logic          fe_clr;
    logic          push_slot;
    logic          empty_w, full_w;
    logic          pop_ok;
    logic          wr_en;
    logic          drop;
    logic [7:0]    par_d;
    logic          par_pe;
    logic          level_hit;

    assign rx_edge = sync2_q & ~prev_q;
    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == DEPTH_C);
    assign pop_ok  = rd_req & ~empty_w;

    // A full FIFO can still take the word when a pop retires an entry on the
    // same edge: the freed slot is the one being written.
    assign wr_en   = push_slot & (~full_w | pop_ok);
    assign drop    = push_slot & full_w & ~pop_ok;

    // -----------------------------------------------------------------------
    // Synchroniser and edge register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= rx_wr_req;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // -----------------------------------------------------------------------
    // Capture FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    // Capture FSM: next state and per-state controls. An edge seen while
    // busy is remembered in pend_q and consumed on the next pass through
    // S_IDLE, so back-to-back frames are not lost.
    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        cap_en    = 1'b0;
        fe_clr    = 1'b0;
        push_slot = 1'b0;
        case (state_q)
            S_IDLE: begin
                pend_d = 1'b0;
                if (rx_edge || pend_q) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                pend_d  = pend_q | rx_edge;
                cap_en  = 1'b1;
                fe_clr  = 1'b1;
                state_d = S_PUSH;
            end
            S_PUSH: begin
                pend_d    = pend_q | rx_edge;
                push_slot = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Parity check and capture registers. In 7-bit mode bit 7 is not part of
    // the word, so it is zeroed both for the parity sum and for storage.
    // -----------------------------------------------------------------------
    always_comb begin
        par_d  = word_size ? rx_data[7:0] : {1'b0, rx_data[6:0]};
        par_pe = 1'b0;
        case (parity_mode)
            2'b00:   par_pe = 1'b0;
            2'b01:   par_pe = (^par_d) ^ rx_data[8];
            2'b10:   par_pe = ~((^par_d) ^ rx_data[8]);
            default: par_pe = ~rx_data[8];
        endcase
    end

    always_comb begin
        cap_data_d = cap_data_q;
        cap_fe_d   = cap_fe_q;
        cap_pe_d   = cap_pe_q;
        if (cap_en) begin
            cap_data_d = par_d;
            cap_fe_d   = rx_fe;
            cap_pe_d   = par_pe;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_data_q <= '0;
            cap_fe_q   <= 1'b0;
            cap_pe_q   <= 1'b0;
        end else begin
            cap_data_q <= cap_data_d;
            cap_fe_q   <= cap_fe_d;
            cap_pe_q   <= cap_pe_d;
        end
    end

    // -----------------------------------------------------------------------
    // FIFO storage (no reset needed: only entries below count are read)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= {cap_fe_q, cap_pe_q, cap_data_q};
        end
    end

    // -----------------------------------------------------------------------
    // Pointers, occupancy and read port
    // -----------------------------------------------------------------------
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = pop_ok;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            rd_data_d = mem[rd_ptr_q];
        end
        case ({wr_en, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // -----------------------------------------------------------------------
    // Overrun, timeout and interrupt
    // -----------------------------------------------------------------------
    assign level_hit = (irq_level != '0) && (count_q >= irq_level);

    always_comb begin
        // A drop on the same edge as clr_ov must leave the flag set.
        ov_d = ov_q;
        if (drop) begin
            ov_d = 1'b1;
        end else if (clr_ov) begin
            ov_d = 1'b0;
        end

        tcnt_d = tcnt_q;
        if (wr_en || pop_ok || empty_w) begin
            tcnt_d = '0;
        end else if (brd_tick && (tcnt_q != TO_MAX)) begin
            tcnt_d = tcnt_q + 1'b1;
        end

        to_d = to_q;
        if (pop_ok || empty_w) begin
            to_d = 1'b0;
        end else if (tcnt_d == TO_MAX) begin
            to_d = 1'b1;
        end

        irq_d = level_hit | ov_q | to_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ov_q   <= 1'b0;
            to_q   <= 1'b0;
            tcnt_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            ov_q   <= ov_d;
            to_q   <= to_d;
            tcnt_q <= tcnt_d;
            irq_q  <= irq_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign rx_fe_clr = fe_clr;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign empty     = empty_w;
    assign full      = full_w;
    assign count     = count_q;
    assign overrun   = ov_q;
    assign timeout   = to_q;
    assign irq       = irq_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo_ctrl
//
// Directed bench for uart_rx_fifo_ctrl. A transaction-level model (a queue of
// stored words plus a list of in-flight frames with their due cycle) predicts
// every output; one process compares the DUT to it on each falling edge.
// Literal expectations at key points pin the model itself.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo_ctrl;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int TO    = 32;
    // Cycles from raising rx_wr_req (just after an edge) to the FIFO write
    // edge: two synchroniser flops, edge detect, capture, push.
    localparam int LAT   = 5;

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic          clk;
    logic          reset;
    logic          rx_wr_req;
    logic [8:0]    rx_data;
    logic          rx_fe;
    logic          rx_fe_clr;
    logic [1:0]    parity_mode;
    logic          word_size;
    logic          brd_tick;
    logic          rd_req;
    logic          rd_valid;
    logic [9:0]    rd_data;
    logic [AW:0]   irq_level;
    logic          clr_ov;
    logic          empty;
    logic          full;
    logic [AW:0]   count;
    logic          overrun;
    logic          timeout;
    logic          irq;
    logic [1:0]    dbg_state;

    uart_rx_fifo_ctrl #(
        .DEPTH(DEPTH), .AW(AW), .TIMEOUT_TICKS(TO)
    ) dut (
        .clk(clk), .reset(reset), .rx_wr_req(rx_wr_req), .rx_data(rx_data),
        .rx_fe(rx_fe), .rx_fe_clr(rx_fe_clr), .parity_mode(parity_mode),
        .word_size(word_size), .brd_tick(brd_tick), .rd_req(rd_req),
        .rd_valid(rd_valid), .rd_data(rd_data), .irq_level(irq_level),
        .clr_ov(clr_ov), .empty(empty), .full(full), .count(count),
        .overrun(overrun), .timeout(timeout), .irq(irq), .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Scoreboard / model state
    // ------------------------------------------------------------------
    typedef struct {
        int         due;
        logic [9:0] word;
    } frame_t;

    logic [9:0] exp_q[$];
    frame_t     inflight[$];
    int         cyc;
    int         tcnt;
    logic       m_ov, m_to, m_irq, m_rdv;
    logic [9:0] m_rdd;
    bit         chk_en;
    int         checks;
    int         failures;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        exp_q.delete();
        inflight.delete();
        tcnt  = 0;
        m_ov  = 1'b0;
        m_to  = 1'b0;
        m_irq = 1'b0;
        m_rdv = 1'b0;
        m_rdd = '0;
    endfunction

    function automatic logic [9:0] calc_word(input logic [8:0] r, input logic fe,
                                             input logic [1:0] mode, input logic ws);
        logic [7:0] d;
        logic       pe;
        d = ws ? r[7:0] : {1'b0, r[6:0]};
        case (mode)
            2'b00:   pe = 1'b0;
            2'b01:   pe = (^d) ^ r[8];
            2'b10:   pe = ~((^d) ^ r[8]);
            default: pe = ~r[8];
        endcase
        return {fe, pe, d};
    endfunction

    // Model: advances once per rising edge using the inputs present there.
    always @(posedge clk) begin
        int         pre_size;
        bit         pop, push_due, pushed, dropped;
        logic [9:0] w;
        cyc = cyc + 1;
        if (!reset) begin
            pre_size = exp_q.size();
            pushed   = 0;
            dropped  = 0;
            push_due = 0;
            w        = '0;
            if (inflight.size() > 0 && inflight[0].due == cyc) begin
                push_due = 1;
                w        = inflight[0].word;
                void'(inflight.pop_front());
            end
            m_irq = ((irq_level != 0) && (pre_size >= int'(irq_level))) || m_ov || m_to;
            pop   = rd_req && (pre_size > 0);
            m_rdv = pop;
            if (pop) m_rdd = exp_q.pop_front();
            if (push_due) begin
                if (pre_size < DEPTH || pop) begin
                    exp_q.push_back(w);
                    pushed = 1;
                end else begin
                    dropped = 1;
                end
            end
            if (dropped) m_ov = 1'b1;
            else if (clr_ov) m_ov = 1'b0;
            if (pushed || pop || pre_size == 0) begin
                tcnt = 0;
            end else if (brd_tick && tcnt < TO) begin
                tcnt = tcnt + 1;
                if (tcnt == TO) m_to = 1'b1;
            end
            if (pop || pre_size == 0) m_to = 1'b0;
        end
    end

    // Compare process: every falling edge once enabled.
    always @(negedge clk) begin
        logic exp_fe_clr;
        if (chk_en) begin
            exp_fe_clr = 1'b0;
            foreach (inflight[i]) if (inflight[i].due == cyc + 2) exp_fe_clr = 1'b1;
            chk("count",     32'(count),    32'(exp_q.size()));
            chk("empty",     32'(empty),    32'(exp_q.size() == 0));
            chk("full",      32'(full),     32'(exp_q.size() == DEPTH));
            chk("overrun",   32'(overrun),  32'(m_ov));
            chk("timeout",   32'(timeout),  32'(m_to));
            chk("irq",       32'(irq),      32'(m_irq));
            chk("rd_valid",  32'(rd_valid), 32'(m_rdv));
            chk("rd_data",   32'(rd_data),  32'(m_rdd));
            chk("rx_fe_clr", 32'(rx_fe_clr), 32'(exp_fe_clr));
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks (inputs change 1 time unit after a rising edge)
    // ------------------------------------------------------------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [8:0] d, input logic fe, input bit pop_at_push);
        frame_t f;
        rx_data   = d;
        rx_fe     = fe;
        rx_wr_req = 1'b1;
        f.due     = cyc + LAT;
        f.word    = calc_word(d, fe, parity_mode, word_size);
        inflight.push_back(f);
        step(3);
        rx_wr_req = 1'b0;
        if (pop_at_push) begin
            step(LAT - 4);
            rd_req = 1'b1;
            step(1);
            rd_req = 1'b0;
            step(3);
        end else begin
            step(5);
        end
    endtask

    task automatic pop_n(input int n);
        rd_req = 1'b1;
        step(n);
        rd_req = 1'b0;
        step(1);
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            brd_tick = 1'b1;
            step(1);
            brd_tick = 1'b0;
            step(1);
        end
    endtask

    // Watchdog: the sequence is a few thousand cycles at most.
    initial begin
        #200000;
        $display("FAIL watchdog expired time=%0t", $time);
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        checks      = 0;
        failures    = 0;
        cyc         = 0;
        chk_en      = 0;
        reset       = 1'b1;
        rx_wr_req   = 1'b0;
        rx_data     = '0;
        rx_fe       = 1'b0;
        parity_mode = 2'b01;
        word_size   = 1'b1;
        brd_tick    = 1'b0;
        rd_req      = 1'b0;
        irq_level   = '0;
        clr_ov      = 1'b0;
        model_reset();
        #2 chk_en = 1;
        step(3);
        reset = 1'b0;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);

        // Even parity, 8-bit words.
        send_frame(9'h0A5, 1'b0, 0);
        chk("even_p0_count", 32'(count), 32'd1);
        pop_n(1);
        chk("even_p0_data", 32'(rd_data), 32'h0A5);
        send_frame(9'h1A5, 1'b0, 0);
        pop_n(1);
        chk("even_p1_data", 32'(rd_data), 32'h1A5);

        // Odd parity, 7-bit words.
        parity_mode = 2'b10;
        word_size   = 1'b0;
        send_frame(9'h1FF, 1'b0, 0);
        send_frame(9'h07F, 1'b0, 0);
        pop_n(1);
        chk("odd7_p1_data", 32'(rd_data), 32'h17F);
        pop_n(1);
        chk("odd7_p0_data", 32'(rd_data), 32'h07F);

        // Mark parity with p=0 and a framing error.
        parity_mode = 2'b11;
        word_size   = 1'b1;
        send_frame(9'h055, 1'b1, 0);
        pop_n(1);
        chk("mark_fe_data", 32'(rd_data), 32'h355);

        // Pop while empty: nothing changes.
        rd_req = 1'b1;
        step(1);
        chk("empty_pop_valid", 32'(rd_valid), 32'd0);
        rd_req = 1'b0;
        step(1);
        chk("empty_pop_data", 32'(rd_data), 32'h355);

        // Fill, overflow, clear, overflow-with-pop, drain.
        parity_mode = 2'b00;
        for (int i = 0; i < DEPTH; i++) begin
            send_frame(9'(i * 5 + 16), 1'b0, 0);
        end
        chk("fill_full", 32'(full), 32'd1);
        send_frame(9'h0EE, 1'b0, 0);
        chk("drop_overrun", 32'(overrun), 32'd1);
        chk("drop_count", 32'(count), 32'd16);
        chk("drop_irq", 32'(irq), 32'd1);
        clr_ov = 1'b1;
        step(1);
        clr_ov = 1'b0;
        step(2);
        chk("clr_ov", 32'(overrun), 32'd0);
        send_frame(9'h0DD, 1'b0, 1);
        chk("pushpop_count", 32'(count), 32'd16);
        chk("pushpop_overrun", 32'(overrun), 32'd0);
        pop_n(DEPTH);
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_last", 32'(rd_data), 32'h0DD);

        // Level interrupt at 4.
        irq_level = 5'd4;
        send_frame(9'h011, 1'b0, 0);
        send_frame(9'h022, 1'b0, 0);
        send_frame(9'h033, 1'b0, 0);
        chk("lvl3_irq", 32'(irq), 32'd0);
        send_frame(9'h044, 1'b0, 0);
        chk("lvl4_irq", 32'(irq), 32'd1);
        pop_n(3);
        chk("lvl_order", 32'(rd_data), 32'h033);
        pop_n(1);
        irq_level = '0;

        // Receive timeout.
        send_frame(9'h066, 1'b0, 0);
        tick_n(TO - 1);
        chk("to_before", 32'(timeout), 32'd0);
        tick_n(1);
        chk("to_set", 32'(timeout), 32'd1);
        step(1);
        chk("to_irq", 32'(irq), 32'd1);
        pop_n(1);
        chk("to_cleared", 32'(timeout), 32'd0);

        // Reset while the FSM sits in its push state: no write must land.
        begin
            frame_t f;
            rx_data   = 9'h0AB;
            rx_fe     = 1'b0;
            rx_wr_req = 1'b1;
            f.due     = cyc + LAT;
            f.word    = calc_word(9'h0AB, 1'b0, parity_mode, word_size);
            inflight.push_back(f);
            step(3);
            rx_wr_req = 1'b0;
            step(LAT - 4);
            reset = 1'b1;
            model_reset();
            #2;
            chk("midrst_rd_data", 32'(rd_data), 32'd0);
            step(2);
            reset = 1'b0;
            step(6);
            chk("midrst_empty", 32'(empty), 32'd1);
            chk("midrst_count", 32'(count), 32'd0);
        end

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
